payload_char_feeder: RTL and testbench

Byte-serialising front end for the payload match engines. Accepts packet payload as 64-bit stream words, emits one byte per cycle as a multi-hot character-class vector with `eng_en`, pulses `eng_sod` before each packet, flushes the engine pipelines after the last byte, and returns the sampled per-engine match vector as one result per packet. It drives every `in_*`/`en`/`sod` input of the engine array and consumes every engine `out`.

---
 rtl/payload_pkg.sv | 24 ++
 rtl/payload_class_table.sv | 24 ++
 rtl/payload_char_feeder.sv | 162 ++++++++++++++++
 tb/tb_payload_char_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_pkg.sv
// Shared types and constants for the payload character feeder and its class table.
package payload_pkg;

   localparam int BYTE_LANES   = 8;
   localparam int CLASS_ADDR_W = 8;
   localparam int LANE_W       = $clog2(BYTE_LANES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOD,
      ST_STREAM,
      ST_FLUSH,
      ST_REPORT
   } state_e;

   // Index of the lowest set bit; zero when the mask is empty.
   function automatic logic [LANE_W-1:0] lowest_lane(input logic [BYTE_LANES-1:0] mask);
      lowest_lane = '0;
      for (int i = BYTE_LANES - 1; i >= 0; i--) begin
         if (mask[i]) lowest_lane = LANE_W'(i);
      end
   endfunction

endpackage

// File: rtl/payload_class_table.sv
// 256-entry byte-to-class lookup RAM with one write port and a registered read.
// A same-address read and write in one cycle returns the previous contents.
module payload_class_table
   import payload_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [CLASS_ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [CLASS_ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0]       rd_data
);

   logic [DATA_W-1:0] mem [2**CLASS_ADDR_W];

   // Contents survive reset; only the write port changes them.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/payload_char_feeder.sv
// Serialises payload words into per-byte class vectors for the match engines,
// then flushes the engine pipelines and returns one sampled match vector per packet.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a packet; stream not ready
// ST_SOD    | engine clear pulse; first word may be accepted
// ST_STREAM | emitting one byte per cycle from the lane buffer
// ST_FLUSH  | zero-class enable cycles, then sample engine outputs
// ST_REPORT | holding the result until the consumer takes it
module payload_char_feeder
   import payload_pkg::*;
#(
   parameter int NUM_CLASSES  = 64,
   parameter int NUM_ENGINES  = 8,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [63:0]             s_tdata,
   input  logic [BYTE_LANES-1:0]   s_tkeep,
   input  logic                    s_tlast,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic                    cls_wr_en,
   input  logic [CLASS_ADDR_W-1:0] cls_wr_addr,
   input  logic [NUM_CLASSES-1:0]  cls_wr_data,
   output logic                    eng_sod,
   output logic                    eng_en,
   output logic [NUM_CLASSES-1:0]  eng_char,
   input  logic [NUM_ENGINES-1:0]  eng_match,
   output logic [NUM_ENGINES-1:0]  m_result,
   output logic                    m_valid,
   input  logic                    m_ready
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   state_e                  state_q, state_d;
   logic [63:0]             data_q, data_d;
   logic [BYTE_LANES-1:0]   mask_q, mask_d;
   logic                    last_q, last_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    en_q, en_d;
   logic                    byte_q, byte_d;
   logic                    capture;
   logic                    ready;
   logic                    single;
   logic [LANE_W-1:0]       lane;
   logic [CLASS_ADDR_W-1:0] rd_addr;
   logic [NUM_CLASSES-1:0]  cls_q;

   assign lane    = lowest_lane(mask_q);
   assign rd_addr = data_q[{lane, 3'b000} +: 8];
   assign single  = (mask_q != '0) && ((mask_q & (mask_q - BYTE_LANES'(1))) == '0);

   payload_class_table #(
      .DATA_W (NUM_CLASSES)
   ) u_class_table (
      .clk     (clk),
      .wr_en   (cls_wr_en),
      .wr_addr (cls_wr_addr),
      .wr_data (cls_wr_data),
      .rd_addr (rd_addr),
      .rd_data (cls_q)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mask_d  = mask_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      en_d    = 1'b0;
      byte_d  = 1'b0;
      capture = 1'b0;
      ready   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_tvalid) state_d = ST_SOD;
         end
         ST_SOD: begin
            ready   = 1'b1;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (mask_q != '0) begin
               en_d   = 1'b1;
               byte_d = 1'b1;
               mask_d = mask_q & (mask_q - BYTE_LANES'(1));
               if (single) begin
                  if (last_q) begin
                     state_d = ST_FLUSH;
                     cnt_d   = CNT_W'(FLUSH_CYCLES);
                     last_d  = 1'b0;
                  end else begin
                     ready = 1'b1;
                  end
               end
            end else if (last_q) begin
               // Last word carried no bytes: this cycle already counts as the first flush cycle.
               en_d    = 1'b1;
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
               last_d  = 1'b0;
            end else begin
               ready = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt_q != '0) begin
               en_d  = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               capture = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (m_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (ready && s_tvalid) begin
         data_d = s_tdata;
         mask_d = s_tkeep;
         last_d = s_tlast;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         mask_q   <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         byte_q   <= 1'b0;
         m_result <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         byte_q  <= byte_d;
         if (capture) m_result <= eng_match;
      end
   end

   // Engines are held clear for the whole of reset, not only the SOD cycle.
   assign eng_sod  = !rst_n || (state_q == ST_SOD);
   assign eng_en   = en_q;
   assign eng_char = byte_q ? cls_q : '0;
   assign s_tready = ready;
   assign m_valid  = (state_q == ST_REPORT);

endmodule

// File: tb/tb_payload_char_feeder.sv
// Randomised bench for payload_char_feeder: per-packet expected class stream,
// flush length, result timing and handshake behaviour from a behavioural model.
module tb_payload_char_feeder;

   localparam int F = 2;

   logic        clk;
   logic        rst_n;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tlast;
   logic        s_tvalid;
   logic        s_tready;
   logic        cls_wr_en;
   logic [7:0]  cls_wr_addr;
   logic [63:0] cls_wr_data;
   logic        eng_sod;
   logic        eng_en;
   logic [63:0] eng_char;
   logic [7:0]  eng_match;
   logic [7:0]  m_result;
   logic        m_valid;
   logic        m_ready;

   int checks;
   int failures;

   logic [63:0] class_model [256];
   logic [63:0] tx_data [$];
   logic [7:0]  tx_keep [$];
   logic [63:0] exp_char [$];

   payload_char_feeder #(
      .NUM_CLASSES  (64),
      .NUM_ENGINES  (8),
      .FLUSH_CYCLES (F)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_tdata     (s_tdata),
      .s_tkeep     (s_tkeep),
      .s_tlast     (s_tlast),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .cls_wr_en   (cls_wr_en),
      .cls_wr_addr (cls_wr_addr),
      .cls_wr_data (cls_wr_data),
      .eng_sod     (eng_sod),
      .eng_en      (eng_en),
      .eng_char    (eng_char),
      .eng_match   (eng_match),
      .m_result    (m_result),
      .m_valid     (m_valid),
      .m_ready     (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic write_cls(input logic [7:0] a, input logic [63:0] d);
      @(posedge clk); #1;
      cls_wr_en   = 1'b1;
      cls_wr_addr = a;
      cls_wr_data = d;
      class_model[a] = d;
      @(posedge clk); #1;
      cls_wr_en = 1'b0;
   endtask

   // Random packet of n bytes; sparse keeps leave garbage in unused lanes.
   task automatic build_random(input int n, input bit full);
      int          placed;
      logic [63:0] w;
      logic [7:0]  k;
      bit          use_lane;
      tx_data.delete();
      tx_keep.delete();
      exp_char.delete();
      placed = 0;
      while (placed < n || tx_data.size() == 0) begin
         w = {$urandom, $urandom};
         k = '0;
         for (int l = 0; l < 8; l++) begin
            use_lane = full ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (use_lane && placed < n) begin
               k[l] = 1'b1;
               exp_char.push_back(class_model[w[l*8 +: 8]]);
               placed++;
            end
         end
         tx_data.push_back(w);
         tx_keep.push_back(k);
      end
   endtask

   task automatic run_packet(input bit timed, input bit gaps, input int hold, input logic [7:0] mval,
                             input int wr_cyc, input logic [7:0] wr_a, input logic [63:0] wr_d);
      int nbytes;
      int nwords;
      nbytes = exp_char.size();
      nwords = tx_data.size();
      for (int i = 0; i < F; i++) exp_char.push_back('0);
      fork
         begin
            bit hs;
            int guard;
            for (int w = 0; w < nwords; w++) begin
               if (gaps && w > 0 && $urandom_range(0, 1) == 1) begin
                  s_tvalid = 1'b0;
                  @(posedge clk); #1;
               end
               s_tvalid = 1'b1;
               s_tdata  = tx_data[w];
               s_tkeep  = tx_keep[w];
               s_tlast  = (w == nwords - 1);
               hs = 1'b0;
               guard = 0;
               while (!hs && guard < 200) begin
                  @(negedge clk);
                  hs = s_tready;
                  @(posedge clk); #1;
                  guard++;
               end
               if (!hs) check_val("drv_timeout", 64'(hs), 64'(1));
            end
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
         begin
            int cyc, s_cyc, en_cnt, first_en, last_en, ready_cnt, sod_cnt;
            bit done, contiguous;
            cyc = 0; s_cyc = -1; en_cnt = 0; first_en = -1; last_en = -1;
            ready_cnt = 0; sod_cnt = 0; done = 1'b0; contiguous = 1'b1;
            eng_match = mval ^ 8'hFF;
            while (!done && cyc < 400) begin
               @(negedge clk);
               cyc++;
               if (wr_cyc >= 0 && s_cyc >= 0 && cyc == s_cyc + wr_cyc) begin
                  cls_wr_en   = 1'b1;
                  cls_wr_addr = wr_a;
                  cls_wr_data = wr_d;
               end else begin
                  cls_wr_en = 1'b0;
               end
               if (eng_sod) begin
                  if (s_cyc < 0) s_cyc = cyc;
                  sod_cnt++;
                  check_val("sod_en_overlap", 64'(eng_en), 64'(0));
               end
               if (s_tready && s_cyc >= 0) ready_cnt++;
               if (eng_en) begin
                  if (exp_char.size() == 0) check_val("extra_en", 64'(1), 64'(0));
                  else check_val("eng_char", eng_char, exp_char.pop_front());
                  if (last_en >= 0 && cyc != last_en + 1) contiguous = 1'b0;
                  if (first_en < 0) first_en = cyc;
                  last_en = cyc;
                  en_cnt++;
               end
               eng_match = (s_cyc >= 0 && exp_char.size() <= F) ? mval : (mval ^ 8'hFF);
               if (m_valid) begin
                  done = 1'b1;
                  if (timed) check_val("mvalid_time", 64'(cyc - s_cyc), 64'(nbytes + F + 2));
                  check_val("flush_left", 64'(exp_char.size()), 64'(0));
                  check_val("m_result", 64'(m_result), 64'(mval));
                  check_val("report_ready", 64'(s_tready), 64'(0));
                  eng_match = ~mval;
                  for (int h = 0; h < hold; h++) begin
                     @(negedge clk);
                     check_val("hold_valid", 64'(m_valid), 64'(1));
                     check_val("hold_result", 64'(m_result), 64'(mval));
                  end
                  m_ready = 1'b1;
                  @(negedge clk);
                  m_ready = 1'b0;
                  check_val("idle_after_ready", 64'(m_valid), 64'(0));
               end
            end
            cls_wr_en = 1'b0;
            if (!done) check_val("result_timeout", 64'(done), 64'(1));
            check_val("sod_count", 64'(sod_cnt), 64'(1));
            if (timed) begin
               check_val("en_count", 64'(en_cnt), 64'(nbytes + F));
               check_val("en_contiguous", 64'(contiguous), 64'(1));
               check_val("first_en", 64'(first_en - s_cyc), 64'(2));
            end
            if (!gaps) check_val("ready_count", 64'(ready_cnt), 64'(nwords));
         end
      join
   endtask

   initial begin
      logic [63:0] old_v, new_v;
      checks = 0; failures = 0;
      rst_n = 1'b0;
      s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
      cls_wr_en = 1'b0; cls_wr_addr = '0; cls_wr_data = '0;
      eng_match = '0; m_ready = 1'b0;
      #2;
      check_val("rst_sod", 64'(eng_sod), 64'(1));
      check_val("rst_en", 64'(eng_en), 64'(0));
      check_val("rst_char", eng_char, 64'(0));
      check_val("rst_ready", 64'(s_tready), 64'(0));
      check_val("rst_mvalid", 64'(m_valid), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 check_val("sod_released", 64'(eng_sod), 64'(0));

      for (int a = 0; a < 256; a++) write_cls(8'(a), {$urandom, $urandom});
      write_cls(8'h61, 64'h10);
      old_v = class_model[8'h2F] & ~64'h100;
      write_cls(8'h2F, old_v);

      // "abc" in one word
      tx_data = '{64'h0000_0000_0063_6261};
      tx_keep = '{8'h07};
      exp_char = '{class_model[8'h61], class_model[8'h62], class_model[8'h63]};
      run_packet(1, 0, 0, 8'($urandom), -1, 8'h0, 64'h0);

      build_random(16, 1);
      run_packet(1, 0, 1, 8'($urandom), -1, 8'h0, 64'h0);

      build_random(0, 1);
      run_packet(1, 0, 0, 8'($urandom), -1, 8'h0, 64'h0);

      build_random(5, 1);
      run_packet(1, 0, 5, 8'hA5, -1, 8'h0, 64'h0);

      // Write 0x2F while byte 2 of an all-0x2F word is being looked up.
      new_v = old_v | 64'h100;
      tx_data = '{64'h2F2F_2F2F_2F2F_2F2F};
      tx_keep = '{8'hFF};
      exp_char = '{old_v, old_v, old_v, new_v, new_v, new_v, new_v, new_v};
      run_packet(1, 0, 0, 8'($urandom), 3, 8'h2F, new_v);
      class_model[8'h2F] = new_v;

      // Reset in the middle of a word.
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 1'b1;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_val("mid_rst_sod", 64'(eng_sod), 64'(1));
      check_val("mid_rst_en", 64'(eng_en), 64'(0));
      check_val("mid_rst_char", eng_char, 64'(0));
      check_val("mid_rst_ready", 64'(s_tready), 64'(0));
      check_val("mid_rst_mvalid", 64'(m_valid), 64'(0));
      check_val("mid_rst_result", 64'(m_result), 64'(0));
      s_tvalid = 1'b0; s_tlast = 1'b0;
      @(posedge clk); #1;
      check_val("mid_rst_sod_held", 64'(eng_sod), 64'(1));
      @(negedge clk) rst_n = 1'b1;
      #1 check_val("mid_rst_sod_rel", 64'(eng_sod), 64'(0));
      build_random(11, 1);
      run_packet(1, 0, 0, 8'($urandom), -1, 8'h0, 64'h0);

      for (int p = 0; p < 30; p++) begin
         bit full, gaps;
         full = ($urandom_range(0, 1) == 1);
         gaps = ($urandom_range(0, 2) == 0);
         build_random($urandom_range(0, 24), full);
         run_packet(full && !gaps, gaps, $urandom_range(0, 3), 8'($urandom), -1, 8'h0, 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
